gcd_job_dispatcher: RTL and testbench

Front-end stage for the Greatest_Common_Divisor core. Accepts a stream of operand pairs over valid/ready and buffers them in a small FIFO. Issues each pair to the core with a one-cycle `Begin` pulse, holding operands stable, and captures the result on the rising edge of `Complete`. Returns `{a, b, gcd}` on a valid/ready result port, with a zero-operand bypass and a watchdog timeout.

---
 rtl/gcd_pkg.sv | 31 +++
 rtl/gcd_operand_fifo.sv | 60 ++++++
 rtl/gcd_job_dispatcher.sv | 179 +++++++++++++++++
 tb/tb_gcd_job_dispatcher.sv | 572 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the GCD job dispatcher slice.
//   GCD_WIDTH    - default operand/result width (must match the GCD core)
//   gcd_state_e  - dispatcher FSM states
//   gcd_bypass() - zero-operand shortcut: returns {hit, a | b}
package gcd_pkg;

    localparam int unsigned GCD_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } gcd_state_e;

    typedef struct packed {
        logic                 hit;
        logic [GCD_WIDTH-1:0] value;
    } gcd_bypass_t;

    // gcd(x, 0) = x and gcd(0, 0) = 0, so OR-ing the operands gives the
    // result whenever either of them is zero.
    function automatic gcd_bypass_t gcd_bypass(input logic [GCD_WIDTH-1:0] a,
                                               input logic [GCD_WIDTH-1:0] b);
        gcd_bypass_t r;
        r.hit   = (a == '0) || (b == '0);
        r.value = a | b;
        return r;
    endfunction

endpackage

// File: rtl/gcd_operand_fifo.sv
// gcd_operand_fifo: synchronous first-word-fall-through FIFO for operand pairs.
//   clk_i, rst_i   - clock, synchronous active-high reset
//   push_i, data_i - write request and data (ignored when full)
//   pop_i          - read request (ignored when empty)
//   head_o         - current head entry, valid whenever empty_o is 0
//   full_o, empty_o- occupancy flags
module gcd_operand_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
    // that differ only in the wrap bit mean full.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/gcd_job_dispatcher.sv
// gcd_job_dispatcher: front end for the GCD core. Buffers operand pairs,
// issues them to the core one at a time and returns {a, b, gcd}.
//   clk_i, rst_i            - clock, synchronous active-high reset
//   in_valid_i/in_ready_o   - operand pair input (in_a_i, in_b_i)
//   core_begin_o            - one-cycle start pulse to the core
//   core_a_o, core_b_o      - operands to the core, held until the next load
//   core_complete_i         - core Complete (level, may stay high many cycles)
//   core_gcd_i              - core result
//   out_valid_o/out_ready_i - result output (out_a_o, out_b_o, out_gcd_o, out_err_o)
//   out_err_o               - result came from the watchdog; out_gcd_o is 0
//   busy_o                  - a job is in flight or the FIFO holds entries
//   dbg_state_o             - current FSM state
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both 1; the producer holds its payload stable
// while valid is 1 and ready is 0.
module gcd_job_dispatcher
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH   = GCD_WIDTH,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic             core_begin_o,
    output logic [WIDTH-1:0] core_a_o,
    output logic [WIDTH-1:0] core_b_o,
    input  logic             core_complete_i,
    input  logic [WIDTH-1:0] core_gcd_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_a_o,
    output logic [WIDTH-1:0] out_b_o,
    output logic [WIDTH-1:0] out_gcd_o,
    output logic             out_err_o,
    output logic             busy_o,
    output gcd_state_e       dbg_state_o
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    gcd_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              prev_complete_q;
    logic [WIDTH-1:0]  core_a_q, core_a_d;
    logic [WIDTH-1:0]  core_b_q, core_b_d;
    logic [WIDTH-1:0]  out_a_q, out_a_d;
    logic [WIDTH-1:0]  out_b_q, out_b_d;
    logic [WIDTH-1:0]  out_gcd_q, out_gcd_d;
    logic              out_err_q, out_err_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [2*WIDTH-1:0] fifo_head;
    logic [WIDTH-1:0]  head_a;
    logic [WIDTH-1:0]  head_b;
    logic              complete_rise;
    gcd_bypass_t       byp;

    // No pass-through: a full FIFO refuses input even if it pops this cycle.
    assign in_ready_o = !fifo_full;

    gcd_operand_fifo #(
        .DEPTH (DEPTH),
        .DW    (2*WIDTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (in_valid_i),
        .data_i  ({in_a_i, in_b_i}),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_a        = fifo_head[2*WIDTH-1:WIDTH];
    assign head_b        = fifo_head[WIDTH-1:0];
    assign byp           = gcd_bypass(GCD_WIDTH'(head_a), GCD_WIDTH'(head_b));
    // Only a fresh 0->1 transition of Complete counts as a result.
    assign complete_rise = core_complete_i && !prev_complete_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        core_a_d  = core_a_q;
        core_b_d  = core_b_q;
        out_a_d   = out_a_q;
        out_b_d   = out_b_q;
        out_gcd_d = out_gcd_q;
        out_err_d = out_err_q;
        fifo_pop  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Waiting for Complete to drop keeps a lingering Complete
                // from the previous job from being taken as this job's result.
                if (!fifo_empty && !core_complete_i) begin
                    fifo_pop = 1'b1;
                    core_a_d = head_a;
                    core_b_d = head_b;
                    out_a_d  = head_a;
                    out_b_d  = head_b;
                    if (byp.hit) begin
                        out_gcd_d = WIDTH'(byp.value);
                        out_err_d = 1'b0;
                        state_d   = ST_RESULT;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The rising edge takes priority over the watchdog.
                if (complete_rise) begin
                    out_gcd_d = core_gcd_i;
                    out_err_d = 1'b0;
                    state_d   = ST_RESULT;
                end else if (cnt_q == CNT_LAST) begin
                    out_gcd_d = '0;
                    out_err_d = 1'b1;
                    state_d   = ST_RESULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESULT: begin
                if (out_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            prev_complete_q <= 1'b0;
            core_a_q        <= '0;
            core_b_q        <= '0;
            out_a_q         <= '0;
            out_b_q         <= '0;
            out_gcd_q       <= '0;
            out_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            prev_complete_q <= core_complete_i;
            core_a_q        <= core_a_d;
            core_b_q        <= core_b_d;
            out_a_q         <= out_a_d;
            out_b_q         <= out_b_d;
            out_gcd_q       <= out_gcd_d;
            out_err_q       <= out_err_d;
        end
    end

    assign core_begin_o = (state_q == ST_ISSUE);
    assign core_a_o     = core_a_q;
    assign core_b_o     = core_b_q;
    assign out_valid_o  = (state_q == ST_RESULT);
    assign out_a_o      = out_a_q;
    assign out_b_o      = out_b_q;
    assign out_gcd_o    = out_gcd_q;
    assign out_err_o    = out_err_q;
    assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_gcd_job_dispatcher.sv
module tb_gcd_job_dispatcher;
    import gcd_pkg::*;

    localparam int W       = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 256;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic             core_begin;
    logic [W-1:0]     core_a;
    logic [W-1:0]     core_b;
    logic             core_complete = 1'b0;
    logic [W-1:0]     core_gcd = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_a;
    logic [W-1:0]     out_b;
    logic [W-1:0]     out_gcd;
    logic             out_err;
    logic             busy;
    gcd_state_e       dbg_state;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;

    // Behavioural core model controls and observations
    int  lat = 5;
    int  hold = 3;
    bit  never_complete = 1'b0;
    int  cm_delay = 0;
    int  cm_hold = 0;
    logic [W-1:0] cm_gcd = '0;
    int  begin_log[$];
    int  rise_log[$];
    int  fall_log[$];

    // Scoreboard: entries are {a, b, gcd, err}
    logic [3*W:0] exp_q[$];
    logic [3*W:0] got_q[$];
    logic         prev_valid = 1'b0;
    int           valid_rise_cyc = -1;

    gcd_job_dispatcher #(
        .WIDTH   (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_a_i          (in_a),
        .in_b_i          (in_b),
        .core_begin_o    (core_begin),
        .core_a_o        (core_a),
        .core_b_o        (core_b),
        .core_complete_i (core_complete),
        .core_gcd_i      (core_gcd),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_a_o         (out_a),
        .out_b_o         (out_b),
        .out_gcd_o       (out_gcd),
        .out_err_o       (out_err),
        .busy_o          (busy),
        .dbg_state_o     (dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit hit, tests_run=%0d", tests_run);
        $fatal(1, "time limit");
    end

    // ---------------- reference arithmetic ----------------
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        if (a == 0 || b == 0) return a | b;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [3*W:0] mk_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input bit timed_out);
        if (timed_out && a != 0 && b != 0) return {a, b, {W{1'b0}}, 1'b1};
        return {a, b, ref_gcd(a, b), 1'b0};
    endfunction

    // ---------------- behavioural GCD core ----------------
    initial forever begin
        @(negedge clk);
        if (core_begin) begin
            begin_log.push_back(cyc);
            cm_gcd   = ref_gcd(core_a, core_b);
            cm_delay = never_complete ? 0 : lat;
        end else if (cm_delay > 0) begin
            cm_delay--;
            if (cm_delay == 0) begin
                core_gcd      = cm_gcd;
                core_complete = 1'b1;
                cm_hold       = hold;
                rise_log.push_back(cyc);
            end
        end else if (cm_hold > 0) begin
            cm_hold--;
            if (cm_hold == 0) begin
                core_complete = 1'b0;
                fall_log.push_back(cyc);
            end
        end
    end

    // ---------------- result monitor ----------------
    initial forever begin
        @(negedge clk);
        if (out_valid && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = out_valid;
        if (out_valid && out_ready) got_q.push_back({out_a, out_b, out_gcd, out_err});
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                             output bit ok, output int edge_cyc);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = in_ready;
        if (ok) begin
            @(posedge clk);
            #1;
        end
        edge_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int limit, output bit ok);
        int i = 0;
        while (got_q.size() < n && i < limit) begin
            @(negedge clk);
            i++;
        end
        @(posedge clk);
        #1;
        ok = (got_q.size() >= n);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        settle(3);
        tests_run++;
        if (core_begin !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: core_begin=%b out_valid=%b, required 0 0", core_begin, out_valid);
        end
        rst = 1'b0;
        settle(1);
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: in_ready=%b busy=%b out_err=%b, required 1 0 0", in_ready, busy, out_err);
        end
        tests_run++;
        if ({core_a, core_b, out_a, out_b, out_gcd} !== '0) begin
            fails++;
            $display("FAIL reset_data: core_a=%h core_b=%h out_a=%h out_b=%h out_gcd=%h, required all 0",
                     core_a, core_b, out_a, out_b, out_gcd);
        end
        tests_run++;
        if (dbg_state !== ST_IDLE) begin
            fails++;
            $display("FAIL reset_state: state=%0d, required %0d", dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_single_job;
        bit ok;
        int pe;
        logic [3*W:0] g;
        logic [3*W:0] e;
        begin_log.delete();
        rise_log.delete();
        lat = 5;
        hold = 3;
        out_ready = 1'b1;
        push_wait(16'd12, 16'd18, ok, pe);
        if (ok) exp_q.push_back(mk_exp(16'd12, 16'd18, 1'b0));
        wait_results(1, 100, ok);
        settle(8);
        tests_run++;
        if (begin_log.size() != 1 || begin_log[0] != pe + 1) begin
            fails++;
            $display("FAIL single_begin: begin count=%0d at cycle %0d, required 1 at cycle %0d",
                     begin_log.size(), (begin_log.size() > 0) ? begin_log[0] : -1, pe + 1);
        end
        tests_run++;
        if (valid_rise_cyc != rise_log[0] + 1) begin
            fails++;
            $display("FAIL single_latency: out_valid rose at %0d, required %0d", valid_rise_cyc, rise_log[0] + 1);
        end
        tests_run++;
        if (core_a !== 16'd12 || core_b !== 16'd18) begin
            fails++;
            $display("FAIL single_core_ops: core_a=%0d core_b=%0d, required 12 18", core_a, core_b);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin
                fails++;
                $display("FAIL single_result: none received, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL single_result: got {a,b,gcd,err}=%h, required %h", g, e);
                end
            end
        end
        tests_run++;
        if (got_q.size() != 0) begin
            fails++;
            $display("FAIL single_extra: %0d extra results, required 0", got_q.size());
            got_q.delete();
        end
    endtask

    task automatic test_bypass;
        bit ok;
        int pe;
        logic [3*W:0] g;
        logic [3*W:0] e;
        logic [W-1:0] av[3];
        logic [W-1:0] bv[3];
        av = '{16'd0, 16'd34, 16'd0};
        bv = '{16'd12, 16'd0, 16'd0};
        begin_log.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_wait(av[i], bv[i], ok, pe);
            if (ok) exp_q.push_back(mk_exp(av[i], bv[i], 1'b0));
        end
        wait_results(3, 100, ok);
        settle(4);
        tests_run++;
        if (begin_log.size() != 0) begin
            fails++;
            $display("FAIL bypass_begin: core_begin pulses=%0d, required 0", begin_log.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin
                fails++;
                $display("FAIL bypass_result: none received, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL bypass_result: got {a,b,gcd,err}=%h, required %h", g, e);
                end
            end
        end
        tests_run++;
        if (got_q.size() != 0) begin
            fails++;
            $display("FAIL bypass_extra: %0d extra results, required 0", got_q.size());
            got_q.delete();
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        bit acc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g0;
        logic [3*W:0] g;
        logic [3*W:0] e;
        lat = 3;
        hold = 2;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            g0 = W'($urandom_range(1, 40));
            a  = g0 * W'($urandom_range(1, 500));
            b  = g0 * W'($urandom_range(1, 500));
            in_valid = 1'b1;
            in_a = a;
            in_b = b;
            acc = in_ready;
            if (acc) exp_q.push_back(mk_exp(a, b, 1'b0));
            tests_run++;
            if (acc !== (i < 5)) begin
                fails++;
                $display("FAIL full_accept: push %0d accepted=%b, required %b", i, acc, (i < 5));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        settle(20);
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || got_q.size() != 0) begin
            fails++;
            $display("FAIL full_stall: out_valid=%b in_ready=%b results=%0d, required 1 0 0",
                     out_valid, in_ready, got_q.size());
        end
        out_ready = 1'b1;
        wait_results(5, 200, ok);
        settle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin
                fails++;
                $display("FAIL drain_result: none received, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL drain_result: got {a,b,gcd,err}=%h, required %h", g, e);
                end
            end
        end
        tests_run++;
        if (got_q.size() != 0) begin
            fails++;
            $display("FAIL drain_extra: %0d extra results, required 0", got_q.size());
            got_q.delete();
        end
    endtask

    task automatic test_long_complete;
        bit ok;
        int pe;
        logic [3*W:0] g;
        logic [3*W:0] e;
        begin_log.delete();
        fall_log.delete();
        lat = 2;
        hold = 10;
        out_ready = 1'b1;
        push_wait(16'hFFFF, 16'hFFF0, ok, pe);
        if (ok) exp_q.push_back({16'hFFFF, 16'hFFF0, 16'd15, 1'b0});
        push_wait(16'd21, 16'd14, ok, pe);
        if (ok) exp_q.push_back(mk_exp(16'd21, 16'd14, 1'b0));
        wait_results(2, 200, ok);
        tests_run++;
        if (begin_log.size() < 2 || fall_log.size() < 1 || begin_log[1] <= fall_log[0]) begin
            fails++;
            $display("FAIL long_gate: second begin at %0d, required after Complete fell at %0d",
                     (begin_log.size() > 1) ? begin_log[1] : -1, (fall_log.size() > 0) ? fall_log[0] : -1);
        end
        settle(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin
                fails++;
                $display("FAIL long_result: none received, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL long_result: got {a,b,gcd,err}=%h, required %h", g, e);
                end
            end
        end
        tests_run++;
        if (got_q.size() != 0) begin
            fails++;
            $display("FAIL long_extra: %0d extra results, required 0", got_q.size());
            got_q.delete();
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int pe;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3*W:0] g;
        logic [3*W:0] e;
        begin_log.delete();
        out_ready = 1'b1;
        never_complete = 1'b1;
        a = W'($urandom_range(1, 60000));
        b = W'($urandom_range(1, 60000));
        push_wait(a, b, ok, pe);
        if (ok) exp_q.push_back(mk_exp(a, b, 1'b1));
        wait_results(1, TIMEOUT + 50, ok);
        tests_run++;
        if (!ok || valid_rise_cyc != begin_log[0] + TIMEOUT + 1) begin
            fails++;
            $display("FAIL timeout_time: out_valid rose at %0d, required %0d",
                     valid_rise_cyc, begin_log[0] + TIMEOUT + 1);
        end
        never_complete = 1'b0;
        lat = 4;
        hold = 2;
        push_wait(16'd27, 16'd36, ok, pe);
        if (ok) exp_q.push_back(mk_exp(16'd27, 16'd36, 1'b0));
        wait_results(2, 100, ok);
        settle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin
                fails++;
                $display("FAIL timeout_result: none received, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL timeout_result: got {a,b,gcd,err}=%h, required %h", g, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_job;
        bit ok;
        int pe;
        int n = 0;
        int begins;
        lat = 20;
        hold = 2;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_wait(W'(30 + 7 * i), W'(45 + 5 * i), ok, pe);
        end
        while (dbg_state !== ST_WAIT && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (dbg_state !== ST_WAIT || busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_setup: state=%0d busy=%b, required %0d 1", dbg_state, busy, ST_WAIT);
        end
        rst = 1'b1;
        settle(1);
        rst = 1'b0;
        exp_q.delete();
        begins = begin_log.size();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || core_begin !== 1'b0 || busy !== 1'b0 ||
            {core_a, core_b, out_a, out_b, out_gcd, out_err} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: in_ready=%b out_valid=%b core_begin=%b busy=%b core_a=%h out_gcd=%h out_err=%b, required 1 0 0 0 0 0 0",
                     in_ready, out_valid, core_begin, busy, core_a, out_gcd, out_err);
        end
        settle(40);
        tests_run++;
        if (got_q.size() != 0 || begin_log.size() != begins || dbg_state !== ST_IDLE || core_complete !== 1'b0) begin
            fails++;
            $display("FAIL midreset_stale: results=%0d begins=%0d state=%0d complete=%b, required 0 %0d %0d 0",
                     got_q.size(), begin_log.size(), dbg_state, core_complete, begins, ST_IDLE);
            got_q.delete();
        end
    endtask

    task automatic test_random;
        bit ok;
        int pe;
        int n_ok = 0;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g0;
        logic [3*W:0] g;
        logic [3*W:0] e;
        fork
            begin
                for (int j = 0; j < 10; j++) begin
                    g0 = W'($urandom_range(1, 50));
                    a  = ($urandom_range(0, 5) == 0) ? '0 : g0 * W'($urandom_range(1, 400));
                    b  = ($urandom_range(0, 5) == 0) ? '0 : g0 * W'($urandom_range(1, 400));
                    lat  = $urandom_range(1, 8);
                    hold = $urandom_range(1, 4);
                    push_wait(a, b, ok, pe);
                    if (ok) begin
                        exp_q.push_back(mk_exp(a, b, 1'b0));
                        n_ok++;
                    end
                    settle($urandom_range(0, 3));
                end
            end
            begin
                for (int k = 0; k < 3000 && got_q.size() < 10; k++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        settle(10);
        tests_run++;
        if (n_ok != 10) begin
            fails++;
            $display("FAIL random_accept: accepted %0d pushes, required 10", n_ok);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin
                fails++;
                $display("FAIL random_result: none received, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL random_result: got {a,b,gcd,err}=%h, required %h", g, e);
                end
            end
        end
        tests_run++;
        if (got_q.size() != 0) begin
            fails++;
            $display("FAIL random_extra: %0d extra results, required 0", got_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_job();
        test_bypass();
        test_backpressure();
        test_long_complete();
        test_timeout();
        test_reset_mid_job();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
